// File: rtl/bcd_to_binary_seq_if.sv
// Handshake bundle for bcd_to_binary_seq: input word valid/ready and result valid/ready.
// The converter connects through the slave modport; the producer/consumer uses master.
interface bcd_to_binary_seq_if #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
);
    logic [4*DIGITS-1:0] bcd_input;
    logic                in_valid;
    logic                in_ready;
    logic [BIN_W-1:0]    binary_output;
    logic                out_valid;
    logic                out_ready;
    logic                bcd_error;

    modport master (
        output bcd_input,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  binary_output,
        input  out_valid,
        input  bcd_error
    );

    modport slave (
        input  bcd_input,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output binary_output,
        output out_valid,
        output bcd_error
    );
endinterface

// File: rtl/bcd_to_binary_seq.sv
// Iterative packed-BCD to binary converter, one digit folded per clock, MSD first.
// Optional digit-range checking is enabled by defining BCD2BIN_ERR_CHECK_EN.
module bcd_to_binary_seq #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    bcd_to_binary_seq_if.slave bus
);
    localparam int WW = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

`ifdef BCD2BIN_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WW-1:0]    word_q, word_d;
    logic [BIN_W-1:0] acc_q, acc_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             err_out_q, err_out_d;

    logic [3:0]       digit;
    logic             digit_bad;
    logic             err_now;
    logic [BIN_W-1:0] acc_next;

    // The latched word is shifted left each step, so the current digit is always the top nibble.
    assign digit     = word_q[WW-1 -: 4];
    assign digit_bad = ERR_EN && (digit > 4'd9);
    assign err_now   = err_q | digit_bad;
    assign acc_next  = BIN_W'(({4'b0, acc_q} << 3) + ({4'b0, acc_q} << 1)
                              + {{BIN_W{1'b0}}, digit});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            word_q    <= '0;
            acc_q     <= '0;
            bin_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            err_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            acc_q     <= acc_d;
            bin_q     <= bin_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            err_out_q <= err_out_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        acc_d     = acc_q;
        bin_d     = bin_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        err_out_d = err_out_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    word_d  = bus.bcd_input;
                    acc_d   = '0;
                    cnt_d   = CW'(DIGITS - 1);
                    err_d   = 1'b0;
                    state_d = CONV;
                end
            end
            CONV: begin
                acc_d  = acc_next;
                word_d = word_q << 4;
                err_d  = err_now;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    cnt_d     = '0;
                    bin_d     = err_now ? '0 : acc_next;
                    err_out_d = err_now;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready      = (state_q == IDLE);
    assign bus.out_valid     = (state_q == DONE);
    assign bus.binary_output = bin_q;
    assign bus.bcd_error     = err_out_q;
endmodule
